if_stage_fifo: RTL and testbench
================================

Name: if_stage_fifo

Overview:
Parametrised instruction-fetch stage for the LoongArch pipeline. It generates sequential and redirected PCs and drives a synchronous instruction SRAM with a fixed 1-cycle read latency. Responses are buffered in an in-order instruction FIFO, so decode back-pressure (ds_allowin) never loses or duplicates an instruction. The block sits between the instruction SRAM port and the decode stage. It replaces the single-register, always-advancing PC stage.

Parameters:
PC_W, 32, PC and SRAM address width (≥ 3).
RESET_PC, 32'h1c000000, PC_W-bit address of the first instruction fetched after reset.
IBUF_DEPTH, 4, number of FIFO entries (power of two, ≥ 2).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_en  out  1  read request this cycle
inst_sram_addr  out  PC_W  read address
inst_sram_rdata  in  32  read data, valid the cycle after inst_sram_en
br_taken  in  1  redirect pulse from decode
br_target  in  PC_W  redirect address
ds_allowin  in  1  decode accepts the head entry this cycle
fs_to_ds_valid  out  1  head entry valid
fs_pc  out  PC_W  PC of head entry
fs_inst  out  32  instruction of head entry
fs_adef  out  1  head entry has a misaligned-PC fetch exception

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- State:
  - fetch_pc (PC_W).
  - inflight (1 bit): a response is due this cycle.
  - inflight_adef: the due slot is misaligned.
  - inflight_pc.
  - FIFO of {pc, inst, adef} with rd/wr pointers and count (0..IBUF_DEPTH).
- Reset:
  - fetch_pc=RESET_PC; count, inflight, pointers = 0.
  - While reset is high: inst_sram_en=0, fs_to_ds_valid=0.
  - fs_pc, fs_inst, fs_adef read 0 when count=0.
- Credit rule:
  - credit = (count + inflight < IBUF_DEPTH), using registered values only.
  - A pop in the same cycle grants no extra credit.
- Issue:
  - issue = credit & !reset, with req_pc = fetch_pc.
  - inst_sram_addr = req_pc.
  - inst_sram_en = issue & (req_pc[1:0]==0).
  - On issue: fetch_pc <= req_pc+4 (mod 2^PC_W, wrap silently); inflight <= 1; inflight_adef <= (req_pc[1:0]!=0).
- Response:
  - When inflight=1, push {inflight_pc, adef ? 32'h0 : inst_sram_rdata, inflight_adef} at the clock edge.
  - Request-to-fs_to_ds_valid latency is 2 cycles.
  - Overflow is impossible by the credit rule; an assertion must flag it.
- Output and pop:
  - fs_to_ds_valid = (count!=0) & !br_taken & !reset.
  - Pop when fs_to_ds_valid & ds_allowin.
  - Simultaneous push and pop leaves count unchanged.
- Redirect (br_taken=1):
  - Flush the FIFO (count=0, pointers reset).
  - The inflight response arriving this cycle is dropped (not pushed).
  - Credit is forced true for this cycle; req_pc = br_target.
  - Result: inst_sram_en/addr carry br_target in the same cycle, and fetch_pc <= br_target+4.
  - Head entry is suppressed this cycle: no pop, fs_to_ds_valid=0.
- Misaligned target:
  - No SRAM access.
  - The slot still flows through the FIFO with fs_adef=1 and fs_inst=0.
  - Fetch continues sequentially from target+4; decode is responsible for trapping.
- Reset mid-operation: all state cleared and the FIFO discarded. The first request after release is RESET_PC.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two ports are added:
  - perf_fetch_cnt  out  32: increments on each pop.
  - perf_flush_cnt  out  32: increments each cycle br_taken=1.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, ds_allowin=1, SRAM returns addr^32'hffffffff → en from the first post-reset cycle with addr 0x1c000000, 0x1c000004, …; fs_to_ds_valid rises 2 cycles later with pc 0x1c000000, inst 0xe3ffffff; one instruction per cycle thereafter.
- ds_allowin=0 for 10 cycles → exactly 4 requests issued, then en=0; head held at pc 0x1c000000. Release → pcs 0x1c000000..0x1c00000c delivered in order, no loss or duplicate, fetch resumes at 0x1c000010.
- br_taken=1, br_target=0x1c000100 with 3 entries buffered and one inflight → same cycle: en=1, addr 0x1c000100, fs_to_ds_valid=0. Two cycles later head pc is 0x1c000100; no stale pc appears.
- br_target=0x1c000102 → en=0 that cycle; 2 cycles later head has pc 0x1c000102, fs_adef=1, inst 0. The next request is 0x1c000106 with en=0 (also misaligned).
- Reset asserted for 1 cycle with a full FIFO → the next cycle has fs_to_ds_valid=0; after release the first addr is 0x1c000000.
- With IF_PERF_CNT_EN: 5 pops and 2 redirect cycles → perf_fetch_cnt=5, perf_flush_cnt=2. Preload 32'hffffffff and pop once → perf_fetch_cnt=0.

Source files
------------

// File: rtl/if_stage_fifo.sv
// if_stage_fifo: instruction-fetch stage with 1-cycle SRAM and an in-order credit-managed instruction FIFO.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt/perf_flush_cnt counters.
module if_stage_fifo #(
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c000000),
    parameter int IBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            inst_sram_en,
    output logic [PC_W-1:0] inst_sram_addr,
    input  logic [31:0]     inst_sram_rdata,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            ds_allowin,
    output logic            fs_to_ds_valid,
    output logic [PC_W-1:0] fs_pc,
    output logic [31:0]     fs_inst,
    output logic            fs_adef
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);
    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;
    logic [PC_W-1:0] fetch_pc, inflight_pc, req_pc;
    logic            inflight, inflight_adef, credit, issue, req_adef, push, pop;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [PC_W+32:0] mem [IBUF_DEPTH];
    logic [PC_W+32:0] head;
    // Credit counts the in-flight slot so a response always has room, even without a pop.
    always_comb begin
        credit         = (count + CW'(inflight)) < CW'(IBUF_DEPTH);
        issue          = (credit | br_taken) & ~reset;
        req_pc         = br_taken ? br_target : fetch_pc;
        req_adef       = req_pc[1:0] != 2'b00;
        push           = inflight & ~br_taken;
        fs_to_ds_valid = (count != '0) & ~br_taken & ~reset;
        pop            = fs_to_ds_valid & ds_allowin;
        head           = (count != '0) ? mem[rd_ptr] : '0;
    end
    assign inst_sram_addr = req_pc;
    assign inst_sram_en   = issue & ~req_adef;
    assign {fs_pc, fs_inst, fs_adef} = head;
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_adef <= 1'b0;
            inflight_pc   <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            if (issue) begin
                fetch_pc      <= req_pc + PC_W'(4);
                inflight_pc   <= req_pc;
                inflight_adef <= req_adef;
            end
            inflight <= issue;
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push & ~reset) mem[wr_ptr] <= {inflight_pc, inflight_adef ? 32'h0 : inst_sram_rdata, inflight_adef};
        if (!reset) assert (!(push && !pop && count == CW'(IBUF_DEPTH)));
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (br_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage_fifo.sv
// tb_if_stage_fifo: directed phases plus random stimulus checked against a queue-based fetch model.
module tb_if_stage_fifo;
    localparam int D = 4;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    logic clk = 0, reset = 1, br_taken = 0, ds_allowin = 0;
    logic [31:0] br_target = '0, inst_sram_rdata = '0;
    logic inst_sram_en, fs_to_ds_valid, fs_adef;
    logic [31:0] inst_sram_addr, fs_pc, fs_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
    logic [31:0] m_fcnt = 0, m_bcnt = 0;
`endif
    typedef struct {logic [31:0] pc; logic [31:0] inst; logic adef;} ent_t;
    ent_t q[$];
    logic [31:0] m_fetch = RST_PC, m_ipc = '0;
    logic m_infl = 0;
    int n_chk = 0, n_pass = 0;
    if_stage_fifo #(.PC_W(32), .RESET_PC(RST_PC), .IBUF_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .br_taken(br_taken), .br_target(br_target),
        .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc),
        .fs_inst(fs_inst), .fs_adef(fs_adef)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    initial begin
        logic prev_en = 0;
        logic [31:0] prev_addr = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit credit, issue, exp_en, exp_v;
            logic [31:0] req;
            ent_t h;
            @(negedge clk);
            reset = (cyc < 3) || (cyc == 70) || (cyc > 100 && $urandom_range(0, 63) == 0);
            ds_allowin = (cyc < 21) || (cyc > 30 && cyc < 41) || (cyc > 47 && cyc < 60) || (cyc > 64 && cyc < 101) ||
                         (cyc > 100 && $urandom_range(0, 3) != 0);
            br_taken = (cyc == 45) || (cyc == 52) || (cyc > 100 && $urandom_range(0, 15) == 0);
            br_target = (cyc == 45) ? 32'h1c000100 : (cyc == 52) ? 32'h1c000102 :
                        RST_PC + {$urandom_range(0, 255), 2'b00} + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            inst_sram_rdata = prev_en ? ~prev_addr : $urandom;
            #1;
            credit = (q.size() + int'(m_infl)) < D;
            issue = (credit || br_taken) && !reset;
            req = br_taken ? br_target : m_fetch;
            exp_en = issue && (req[1:0] == 2'b00);
            exp_v = (q.size() != 0) && !br_taken && !reset;
            h = (q.size() != 0) ? q[0] : '{32'h0, 32'h0, 1'b0};
            check("sram_en", 64'(inst_sram_en), 64'(exp_en));
            if (issue) check("sram_addr", 64'(inst_sram_addr), 64'(req));
            check("valid", 64'(fs_to_ds_valid), 64'(exp_v));
            check("fs_pc", 64'(fs_pc), 64'(h.pc));
            check("fs_inst", 64'(fs_inst), 64'(h.inst));
            check("fs_adef", 64'(fs_adef), 64'(h.adef));
`ifdef IF_PERF_CNT_EN
            check("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fcnt));
            check("perf_flush", 64'(perf_flush_cnt), 64'(m_bcnt));
`endif
            prev_en = inst_sram_en;
            prev_addr = inst_sram_addr;
            if (reset) begin
                q.delete();
                m_fetch = RST_PC;
                m_infl = 0;
`ifdef IF_PERF_CNT_EN
                m_fcnt = 0;
                m_bcnt = 0;
`endif
            end else begin
`ifdef IF_PERF_CNT_EN
                if (exp_v && ds_allowin) m_fcnt++;
                if (br_taken) m_bcnt++;
`endif
                if (br_taken) q.delete();
                else begin
                    if (exp_v && ds_allowin) void'(q.pop_front());
                    if (m_infl) q.push_back('{m_ipc, (m_ipc[1:0] != 0) ? 32'h0 : ~m_ipc, m_ipc[1:0] != 0});
                end
                m_infl = issue;
                if (issue) begin
                    m_ipc = req;
                    m_fetch = req + 32'd4;
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
